// File: rtl/md_ctrl_pkg.sv
// md_ctrl_pkg: HI/LO op and FSM encodings shared by the mult/div control path.
package md_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } md_state_e;

    function automatic logic is_start(input logic [3:0] op);
        return op >= OP_MULT && op <= OP_DIVU;
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return op == OP_MULT || op == OP_MULTU;
    endfunction

    // Codes 9-15 behave as NONE, so only 1..8 count as real HI/LO ops.
    function automatic logic is_hilo(input logic [3:0] op);
        return op >= OP_MULT && op <= OP_MTLO;
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// md_ctrl_if: D/E-stage op inputs and issue/stall outputs of the mult/div controller.
interface md_ctrl_if;
    logic [3:0]  d_op;
    logic [3:0]  e_op;
    logic        e_valid;
    logic        e_flush;
    logic [3:0]  md_op;
    logic        stall;
    logic        busy_o;
    logic        proto_err;
    logic [15:0] stall_cnt;

    modport master (
        output d_op, e_op, e_valid, e_flush,
        input  md_op, stall, busy_o, proto_err, stall_cnt
    );

    modport slave (
        input  d_op, e_op, e_valid, e_flush,
        output md_op, stall, busy_o, proto_err, stall_cnt
    );
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: issues HI/LO ops to the mult/div unit, tracks its latency and stalls dependent D-stage ops.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_ctrl_if.slave   bus
);
    md_state_e   r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_err;
    logic [15:0] r_stall_cnt;
    logic        w_live, w_idle, w_go, w_stall, w_bad;

    always_comb begin
        w_live      = bus.e_valid & ~bus.e_flush;
        w_idle      = r_state == IDLE;
        w_go        = w_live & w_idle & is_start(bus.e_op);
        w_bad       = w_live & ~w_idle & is_hilo(bus.e_op);
        w_stall     = is_hilo(bus.d_op) & (~w_idle | w_go);
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_idle) begin
            if (w_go) begin
                w_state_nxt = is_mul(bus.e_op) ? MUL_RUN : DIV_RUN;
                w_cnt_nxt   = is_mul(bus.e_op) ? 4'(MUL_LAT) : 4'(DIV_LAT);
            end
        end else begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1)
                w_state_nxt = IDLE;
        end
    end

    // Moves to/from HI/LO are only safe to issue when nothing is in flight.
    assign bus.md_op     = (w_live & w_idle & is_hilo(bus.e_op)) ? bus.e_op : OP_NONE;
    assign bus.busy_o    = ~w_idle;
    assign bus.stall     = w_stall;
    assign bus.proto_err = r_err;
    assign bus.stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_err       <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_bad)
                r_err <= 1'b1;
            if (w_stall && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameters SHALL be:
  - MUL_LAT, default 5: busy cycles for mult/multu.
  - DIV_LAT, default 10: busy cycles for div/divu.
  - Both parameters SHALL be legal in the range 1..15.
REQ-002 Ports SHALL be, in this order:
  - clk, input, 1: single clock, rising edge.
  - reset, input, 1: synchronous, active-high reset.
  - d_op, input, 4: HI/LO op of the D-stage instruction.
  - e_op, input, 4: HI/LO op of the E-stage instruction.
  - e_valid, input, 1: E-stage instruction is real (not a bubble).
  - e_flush, input, 1: E-stage instruction is being killed this cycle.
  - md_op, output, 4: op driven to the mult/div unit; NONE when nothing is issued.
  - stall, output, 1: freeze F/D and insert an E bubble.
  - busy_o, output, 1: mult/div operation in flight.
  - proto_err, output, 1: sticky flag, illegal start while busy.
  - stall_cnt, output, 16: saturating count of stall cycles.
REQ-003 Op encodings SHALL be: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8; codes 9-15 SHALL be treated as NONE.

Function
REQ-004 The FSM states SHALL be IDLE, MUL_RUN and DIV_RUN, with a 4-bit down-counter cnt.
REQ-005 The block SHALL define go = e_valid & ~e_flush & (state==IDLE) & (e_op in {MULT, MULTU, DIV, DIVU}).
REQ-006 md_op SHALL be combinational: it equals e_op when go is high, or when e_valid & ~e_flush & e_op in {MFHI, MFLO, MTHI, MTLO} & state==IDLE; otherwise it is NONE.
REQ-007 On go with MULT/MULTU, the FSM SHALL move to MUL_RUN and load cnt=MUL_LAT at the next edge; with DIV/DIVU it SHALL move to DIV_RUN and load cnt=DIV_LAT.
REQ-008 In MUL_RUN or DIV_RUN, cnt SHALL decrement by 1 each cycle; at the edge where cnt==1 the FSM SHALL return to IDLE and cnt SHALL become 0.
REQ-009 busy_o SHALL equal (state!=IDLE), so after a go at cycle T busy_o is high for exactly cycles T+1..T+LAT.
REQ-010 stall SHALL be high when d_op is any code in 1..8 and (busy_o | go), so a dependent D op stalls from cycle T through T+LAT and reaches E at cycle T+LAT+1.
REQ-011 stall SHALL be low whenever d_op is NONE, regardless of state.
REQ-012 If e_valid & ~e_flush & state!=IDLE & e_op in 1..8, then md_op SHALL be NONE and proto_err SHALL be set and held until reset.
REQ-013 e_flush SHALL suppress only the E-stage issue; an operation already running SHALL continue to completion.
REQ-014 Back-to-back operations: a start in E at cycle T+LAT+1 SHALL issue with no extra bubble.
REQ-015 stall_cnt SHALL increment on every cycle with stall=1 and saturate at 16'hFFFF.

Reset
REQ-016 When reset is high at a clock edge: state=IDLE, cnt=0, proto_err=0, stall_cnt=0; reset SHALL take priority over go.
REQ-017 During reset, outputs SHALL be: busy_o=0, and md_op/stall driven from current inputs per REQ-006 and REQ-010.
REQ-018 Reset asserted mid-operation SHALL abort the operation: busy_o=0 from the following cycle.

Structure
REQ-019 The op encodings and the state encodings SHALL reside in the shared defines package, used alongside the mult/div unit.
REQ-020 No sub-module SHALL be used; the FSM, counter and stall logic SHALL be in one module instantiated next to multdiv in the E stage.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
  - MULT in E at cycle 10 with d_op=MFLO: md_op=1 at cycle 10; busy_o high 11..15; stall high 10..15; stall_cnt=6.
  - DIVU at cycle 20, then a second DIV arriving at cycle 31: both issue; busy_o high 21..30 and 32..41; proto_err=0.
  - DIV with e_flush=1 at issue: md_op=0, busy_o stays 0, stall=0 for d_op=MFHI.
  - Forced MTHI in E at cycle 3 of a MUL_RUN: md_op=0, proto_err=1 and held; busy_o still drops after 5 cycles.
  - reset asserted at cycle 4 of DIV_RUN: busy_o=0, stall_cnt=0, proto_err=0 at the next cycle; a new MULT issues immediately afterwards.
  - stall held for 70000 cycles: stall_cnt saturates at 65535.
